// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator between the memory stage and data memory.
// In-order store buffer drained one per cycle; loads go to memory or forward.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ld_*                load request (valid/ready, addr, size, signed, tag)
//   ld_resp_*           load response, one cycle after acceptance
//   st_*                committed store (valid/ready, addr, data, size)
//   sb_empty            store buffer empty
//   mem_*               data memory: comb read port, sync write port,
//                       shared transfer size
module lsu_mem_port #(
  parameter int SB_DEPTH  = 4,
  parameter int TAG_W     = 6,
  parameter int DRAIN_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [63:0]      ld_addr,
  input  logic [3:0]       ld_size,
  input  logic             ld_signed,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp_valid,
  output logic [63:0]      ld_resp_data,
  output logic [TAG_W-1:0] ld_resp_tag,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [63:0]      st_addr,
  input  logic [63:0]      st_data,
  input  logic [3:0]       st_size,
  output logic             sb_empty,
  output logic [63:0]      mem_addr_load,
  output logic [63:0]      mem_addr_store,
  output logic             mem_read_enable,
  output logic             mem_write_enable,
  output logic [63:0]      mem_write_data,
  output logic [3:0]       mem_xfer_size,
  input  logic [63:0]      mem_read_data
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(DRAIN_MAX + 1);

  function automatic logic [3:0] norm_size(input logic [3:0] s);
    logic [3:0] r;
    case (s)
      4'd1, 4'd2, 4'd4, 4'd8: r = s;
      default:                r = 4'd8;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] align_addr(
    input logic [63:0] a,
    input logic [3:0]  s
  );
    return a & ~({60'b0, s} - 64'd1);
  endfunction

  // 65-bit ends so ranges touching the top of the space don't wrap
  function automatic logic overlaps(
    input logic [63:0] a1,
    input logic [3:0]  s1,
    input logic [63:0] a2,
    input logic [3:0]  s2
  );
    logic [64:0] e1;
    logic [64:0] e2;
    e1 = {1'b0, a1} + {61'b0, s1};
    e2 = {1'b0, a2} + {61'b0, s2};
    return ({1'b0, a1} < e2) && ({1'b0, a2} < e1);
  endfunction

  function automatic logic [63:0] extend(
    input logic [63:0] d,
    input logic [3:0]  s,
    input logic        sg
  );
    logic [63:0] r;
    case (s)
      4'd1:    r = sg ? {{56{d[7]}}, d[7:0]}
                      : {56'b0, d[7:0]};
      4'd2:    r = sg ? {{48{d[15]}}, d[15:0]}
                      : {48'b0, d[15:0]};
      4'd4:    r = sg ? {{32{d[31]}}, d[31:0]}
                      : {32'b0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [63:0]      sb_addr_q [SB_DEPTH];
  logic [63:0]      sb_addr_d [SB_DEPTH];
  logic [63:0]      sb_data_q [SB_DEPTH];
  logic [63:0]      sb_data_d [SB_DEPTH];
  logic [3:0]       sb_size_q [SB_DEPTH];
  logic [3:0]       sb_size_d [SB_DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             resp_valid_q, resp_valid_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  logic [3:0]    ld_sz, st_sz;
  logic [63:0]   ld_al, st_al;
  logic          full, nonempty, force_drain;
  logic          hit, fwd, blocked;
  logic [PW-1:0] y_idx;
  logic [PW-1:0] cand;
  logic          ld_rdy, st_rdy, rd_en, drain;
  logic          ld_acc, enq;

  always_comb begin
    ld_sz = norm_size(ld_size);
    st_sz = norm_size(st_size);
    ld_al = align_addr(ld_addr, ld_sz);
    st_al = align_addr(st_addr, st_sz);
    full        = count_q == CW'(SB_DEPTH);
    nonempty    = count_q != '0;
    force_drain = (starve_q >= SW'(DRAIN_MAX)) || full;
  end

  // Scan oldest to youngest so the last hit is the youngest overlap.
  always_comb begin
    hit   = 1'b0;
    y_idx = '0;
    cand  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      cand = head_q + PW'(i);
      if ((CW'(i) < count_q) &&
          overlaps(sb_addr_q[cand], sb_size_q[cand],
                   ld_al, ld_sz)) begin
        hit   = 1'b1;
        y_idx = cand;
      end
    end
    fwd = hit &&
          (sb_addr_q[y_idx] == ld_al) &&
          (sb_size_q[y_idx] == ld_sz);
    blocked = hit && !fwd;
  end

  // One user of the shared transfer size per cycle.
  always_comb begin
    ld_rdy = 1'b0;
    st_rdy = 1'b0;
    rd_en  = 1'b0;
    drain  = 1'b0;
    if (!reset) begin
      st_rdy = !full;
      if (!ld_valid) begin
        drain = nonempty;
      end else if (blocked) begin
        drain = nonempty;
      end else if (fwd) begin
        ld_rdy = 1'b1;
        drain  = nonempty;
      end else if (!force_drain) begin
        ld_rdy = 1'b1;
        rd_en  = 1'b1;
      end else begin
        drain = nonempty;
      end
    end
    ld_acc = ld_valid && ld_rdy;
    enq    = st_valid && st_rdy;
  end

  always_comb begin
    mem_read_enable  = rd_en;
    mem_write_enable = drain;
    mem_addr_load    = '0;
    mem_addr_store   = '0;
    mem_write_data   = '0;
    mem_xfer_size    = '0;
    if (rd_en) begin
      mem_addr_load = ld_al;
      mem_xfer_size = ld_sz;
    end
    if (drain) begin
      mem_addr_store = sb_addr_q[head_q];
      mem_write_data = sb_data_q[head_q];
      mem_xfer_size  = sb_size_q[head_q];
    end
  end

  always_comb begin
    sb_addr_d    = sb_addr_q;
    sb_data_d    = sb_data_q;
    sb_size_d    = sb_size_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    starve_d     = starve_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_d[i] = '0;
        sb_data_d[i] = '0;
        sb_size_d[i] = '0;
      end
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      starve_d    = '0;
      resp_data_d = '0;
      resp_tag_d  = '0;
    end else begin
      if (enq) begin
        sb_addr_d[tail_q] = st_al;
        sb_data_d[tail_q] = st_data;
        sb_size_d[tail_q] = st_sz;
        tail_d = tail_q + PW'(1);
      end
      if (drain) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(drain);
      if (drain || !nonempty) begin
        starve_d = '0;
      end else if (starve_q != SW'(DRAIN_MAX)) begin
        starve_d = starve_q + SW'(1);
      end
      resp_valid_d = ld_acc;
      if (ld_acc) begin
        resp_data_d = extend(fwd ? sb_data_q[y_idx]
                                 : mem_read_data,
                             ld_sz, ld_signed);
        resp_tag_d  = ld_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    sb_addr_q    <= sb_addr_d;
    sb_data_q    <= sb_data_d;
    sb_size_q    <= sb_size_d;
    head_q       <= head_d;
    tail_q       <= tail_d;
    count_q      <= count_d;
    starve_q     <= starve_d;
    resp_valid_q <= resp_valid_d;
    resp_data_q  <= resp_data_d;
    resp_tag_q   <= resp_tag_d;
  end

  assign ld_ready      = ld_rdy;
  assign st_ready      = st_rdy;
  assign sb_empty      = count_q == '0;
  assign ld_resp_valid = resp_valid_q;
  assign ld_resp_data  = resp_data_q;
  assign ld_resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed bench for lsu_mem_port with a byte memory model
// and a response scoreboard.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_addr;
  logic [3:0]  ld_size;
  logic        ld_signed;
  logic [5:0]  ld_tag;
  logic        ld_resp_valid;
  logic [63:0] ld_resp_data;
  logic [5:0]  ld_resp_tag;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [3:0]  st_size;
  logic        sb_empty;
  logic [63:0] mem_addr_load;
  logic [63:0] mem_addr_store;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_read_data;

  lsu_mem_port #(
    .SB_DEPTH (4),
    .TAG_W    (6),
    .DRAIN_MAX(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_addr         (ld_addr),
    .ld_size         (ld_size),
    .ld_signed       (ld_signed),
    .ld_tag          (ld_tag),
    .ld_resp_valid   (ld_resp_valid),
    .ld_resp_data    (ld_resp_data),
    .ld_resp_tag     (ld_resp_tag),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_size         (st_size),
    .sb_empty        (sb_empty),
    .mem_addr_load   (mem_addr_load),
    .mem_addr_store  (mem_addr_store),
    .mem_read_enable (mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .mem_write_data  (mem_write_data),
    .mem_xfer_size   (mem_xfer_size),
    .mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];

  always_comb begin
    mem_read_data = '0;
    for (int k = 0; k < 8; k++) begin
      mem_read_data[k*8 +: 8] =
        mem[mem_addr_load[9:0] + 10'(k)];
    end
  end

  // Pattern byte at address a is a[7:0] ^ 8'h90.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= 8'(i) ^ 8'h90;
      end
    end else if (mem_write_enable) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(mem_xfer_size)) begin
          mem[mem_addr_store[9:0] + 10'(k)] <=
            mem_write_data[k*8 +: 8];
        end
      end
    end
  end

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] D2 = 64'hA1B2C3D4E5F60718;

  function automatic logic [63:0] pat_word(
    input logic [63:0] a,
    input int          sz,
    input logic        sg
  );
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < sz; k++) begin
      r[k*8 +: 8] = 8'(a + 64'(k)) ^ 8'h90;
    end
    if (sg && r[sz*8-1] && sz < 8) begin
      r = r | (~64'd0 << (sz * 8));
    end
    return r;
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             name, obs, exp);
    end
  endtask

  task automatic set_ld(
    input logic        v,
    input logic [63:0] a,
    input logic [3:0]  s,
    input logic        sg,
    input logic [5:0]  t,
    input logic [63:0] e
  );
    ld_valid     = v;
    ld_addr      = a;
    ld_size      = s;
    ld_signed    = sg;
    ld_tag       = t;
    exp_cur.tag  = t;
    exp_cur.data = e;
  endtask

  task automatic set_st(
    input logic        v,
    input logic [63:0] a,
    input logic [63:0] d,
    input logic [3:0]  s
  );
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  // Called between negedge and posedge; returns at the next negedge.
  task automatic tick();
    exp_t e;
    if (ld_valid && ld_ready) begin
      exp_q.push_back(exp_cur);
    end
    @(posedge clk);
    #1;
    if (ld_resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(ld_resp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_tag", 64'(ld_resp_tag), 64'(e.tag));
        chk("resp_data", ld_resp_data, e.data);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("resp_missing", 64'(ld_resp_valid), 64'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_ld(0, 0, 0, 0, 0, 0);
    set_st(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("rst_we", 64'(mem_write_enable), 0);
    chk("rst_re", 64'(mem_read_enable), 0);
    chk("rst_xfer", 64'(mem_xfer_size), 0);
    tick();
    tick();

    // store drains on the next idle cycle
    reset = 1'b0;
    set_st(1, 64'h40, D1, 4'd8);
    #1;
    chk("rst_sb_empty", 64'(sb_empty), 1);
    chk("rst_resp_valid", 64'(ld_resp_valid), 0);
    chk("rst_resp_data", ld_resp_data, 0);
    chk("rst_resp_tag", 64'(ld_resp_tag), 0);
    chk("t1_st_ready", 64'(st_ready), 1);
    chk("t1_we_idle", 64'(mem_write_enable), 0);
    tick();
    set_st(0, 0, 0, 0);
    #1;
    chk("t1_we", 64'(mem_write_enable), 1);
    chk("t1_addr_st", mem_addr_store, 64'h40);
    chk("t1_xfer", 64'(mem_xfer_size), 8);
    chk("t1_wdata", mem_write_data, D1);
    chk("t1_not_empty", 64'(sb_empty), 0);
    tick();
    chk("t1_empty", 64'(sb_empty), 1);
    chk("t1_we_off", 64'(mem_write_enable), 0);

    // forward from an exact-match entry, drain alongside
    set_st(1, 64'h40, D2, 4'd8);
    #1;
    tick();
    set_st(0, 0, 0, 0);
    set_ld(1, 64'h40, 4'd8, 0, 6'd5, D2);
    #1;
    chk("t2_ready", 64'(ld_ready), 1);
    chk("t2_no_read", 64'(mem_read_enable), 0);
    chk("t2_we", 64'(mem_write_enable), 1);
    chk("t2_wdata", mem_write_data, D2);
    tick();
    set_ld(0, 0, 0, 0, 0, 0);
    #1;
    chk("t2_empty", 64'(sb_empty), 1);

    // partial overlap blocks until the drain
    set_st(1, 64'h40, D1, 4'd8);
    #1;
    tick();
    set_st(0, 0, 0, 0);
    set_ld(1, 64'h44, 4'd4, 0, 6'd7, 64'h11223344);
    #1;
    chk("t3_blocked", 64'(ld_ready), 0);
    chk("t3_we", 64'(mem_write_enable), 1);
    chk("t3_no_read", 64'(mem_read_enable), 0);
    tick();
    #1;
    chk("t3_ready", 64'(ld_ready), 1);
    chk("t3_re", 64'(mem_read_enable), 1);
    chk("t3_addr_ld", mem_addr_load, 64'h44);
    chk("t3_xfer", 64'(mem_xfer_size), 4);
    tick();

    // sign extension, alignment, invalid size
    set_ld(1, 64'h10, 4'd1, 1, 6'd9, 64'hFFFFFFFFFFFFFF80);
    #1;
    chk("t4_ready", 64'(ld_ready), 1);
    tick();
    set_ld(1, 64'h10, 4'd1, 0, 6'd10, 64'h80);
    #1;
    tick();
    set_ld(1, 64'h13, 4'd2, 1, 6'd11, 64'hFFFFFFFFFFFF8382);
    #1;
    chk("t4_align_h", mem_addr_load, 64'h12);
    tick();
    set_ld(1, 64'h105, 4'd3, 0, 6'd12,
           pat_word(64'h100, 8, 0));
    #1;
    chk("t4_align_d", mem_addr_load, 64'h100);
    chk("t4_xfer_inv", 64'(mem_xfer_size), 8);
    tick();

    // fill the buffer while loads stream
    for (int k = 0; k < 4; k++) begin
      set_ld(1, 64'h100 + 64'(k * 8), 4'd8, 0, 6'(k),
             pat_word(64'h100 + 64'(k * 8), 8, 0));
      set_st(1, 64'h200 + 64'(k * 8),
             64'hC0DE000000000000 | 64'(k), 4'd8);
      #1;
      chk("t5_ld_ready", 64'(ld_ready), 1);
      chk("t5_st_ready", 64'(st_ready), 1);
      tick();
    end
    set_ld(1, 64'h120, 4'd8, 0, 6'd4,
           pat_word(64'h120, 8, 0));
    set_st(1, 64'h220, 64'hC0DE000000000004, 4'd8);
    #1;
    chk("t5_full_st", 64'(st_ready), 0);
    chk("t5_full_ld", 64'(ld_ready), 0);
    chk("t5_full_we", 64'(mem_write_enable), 1);
    chk("t5_full_addr", mem_addr_store, 64'h200);
    chk("t5_full_data", mem_write_data, 64'hC0DE000000000000);
    tick();
    set_st(0, 0, 0, 0);
    #1;
    chk("t5_resume", 64'(ld_ready), 1);
    tick();
    set_ld(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      if (sb_empty) break;
      tick();
    end
    chk("t5_drained", 64'(sb_empty), 1);

    // starvation forces a drain on the ninth cycle
    set_ld(1, 64'h100, 4'd8, 0, 6'd20,
           pat_word(64'h100, 8, 0));
    set_st(1, 64'h300, 64'h0BADF00D0BADF00D, 4'd8);
    #1;
    chk("t6_first", 64'(ld_ready), 1);
    tick();
    set_st(0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      set_ld(1, 64'h100 + 64'(k * 8), 4'd8, 0, 6'(20 + k),
             pat_word(64'h100 + 64'(k * 8), 8, 0));
      #1;
      if (k < 9) begin
        chk("t6_stream_rdy", 64'(ld_ready), 1);
        chk("t6_stream_we", 64'(mem_write_enable), 0);
      end else begin
        chk("t6_force_rdy", 64'(ld_ready), 0);
        chk("t6_force_we", 64'(mem_write_enable), 1);
        chk("t6_force_addr", mem_addr_store, 64'h300);
      end
      tick();
    end
    #1;
    chk("t6_after_rdy", 64'(ld_ready), 1);
    chk("t6_after_we", 64'(mem_write_enable), 0);
    tick();
    set_ld(0, 0, 0, 0, 0, 0);

    // reset with three stores buffered
    for (int k = 0; k < 3; k++) begin
      set_ld(1, 64'h100 + 64'(k * 8), 4'd8, 0, 6'(40 + k),
             pat_word(64'h100 + 64'(k * 8), 8, 0));
      set_st(1, 64'h200 + 64'(k * 8), 64'hFEED0000 | 64'(k),
             4'd8);
      #1;
      tick();
    end
    set_ld(0, 0, 0, 0, 0, 0);
    set_st(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("t7_pre_nonempty", 64'(sb_empty), 0);
    chk("t7_rst_we", 64'(mem_write_enable), 0);
    chk("t7_rst_re", 64'(mem_read_enable), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t7_sb_empty", 64'(sb_empty), 1);
    chk("t7_resp_valid", 64'(ld_resp_valid), 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t7_no_we", 64'(mem_write_enable), 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
